aes_round_engine: RTL and testbench
===================================

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter KEY_TIMEOUT, default 8: maximum cycles between consecutive round keys before an error is raised.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request an encryption; sampled only in IDLE.
REQ-005 SHALL have port plaintext, input, 128: block to encrypt; byte 0 is [127:120]; column-major state per FIPS-197.
REQ-006 SHALL have port key_advance, output, 1: one-cycle pulse that starts the upstream AES-256 round key generator.
REQ-007 SHALL have port round_key, input, 128: round key from the generator.
REQ-008 SHALL have port round_key_valid, input, 1: round_key is valid this cycle; pulses may be separated by idle cycles.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port ciphertext, output, 128: result; held until the next ct_valid.
REQ-011 SHALL have port ct_valid, output, 1: one-cycle pulse marking a new ciphertext.
REQ-012 SHALL have port key_error, output, 1: one-cycle pulse when an encryption is aborted on timeout.

Function
REQ-013 SHALL implement FSM states IDLE, KICK, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture plaintext into the state register, clear key_idx (4 bits), and go to KICK.
REQ-015 SHALL, in KICK, drive key_advance=1 for exactly that cycle, clear the timeout counter, and go to RUN.
REQ-016 SHALL, in RUN, on each cycle with round_key_valid=1, perform the following on the state register and then increment key_idx:
  - key_idx=0: state <= state ^ round_key.
  - key_idx=1..13: state <= MixColumns(ShiftRows(SubBytes(state))) ^ round_key.
  - key_idx=14: state <= ShiftRows(SubBytes(state)) ^ round_key, then go to DONE.
REQ-017 SHALL leave the state register unchanged on RUN cycles with round_key_valid=0.
REQ-018 SHALL perform a full round in one cycle: 16 S-box lookups, with MixColumns using xtime and GF(2^8) reduction polynomial 0x11B.
REQ-019 SHALL, in DONE, load ciphertext from the state register, pulse ct_valid=1, and return to IDLE.
REQ-020 SHALL start a new block no earlier than the cycle after DONE; start is not accepted in DONE.
REQ-021 SHALL ignore start while busy=1; no queuing.
REQ-022 SHALL ignore round_key_valid outside RUN, including a stray pulse in IDLE.
REQ-023 SHALL keep a timeout counter in RUN that:
  - clears on each round_key_valid;
  - otherwise increments by 1;
  - on reaching KICK_TIMEOUT... specifically KEY_TIMEOUT, pulses key_error=1, leaves ciphertext unchanged, suppresses ct_valid, and returns to IDLE.
REQ-024 SHALL use a 4-bit key_idx that never wraps; exactly 15 keys are consumed per block.
REQ-025 SHALL give priority to round_key_valid=1 on the timeout cycle: the key is consumed and no error is raised.
REQ-026 SHALL give latency from accepted start to ct_valid of (cycle of 15th key) + 1; with back-to-back keys every 4 cycles, that is roughly 62 cycles.
REQ-027 SHALL register key_advance, busy, ct_valid and key_error directly from FSM state; they are glitch-free.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge:
  - force IDLE;
  - clear the state register, ciphertext, key_idx and timeout counter to 0;
  - drive key_advance, busy, ct_valid and key_error to 0.
REQ-029 SHALL abort any in-flight block on reset without asserting ct_valid or key_error.

Verification
REQ-030 SHALL verify the FIPS-197 C.3 vector: key 000102..1f paired with the real generator, plaintext 00112233445566778899aabbccddeeff -> ct_valid once, ciphertext 8ea2b7ca516745bfeafc49904b496089.
REQ-031 SHALL verify with a behavioural key source giving 15 keys with random 0-5 cycle gaps, same vector -> identical ciphertext, one ct_valid, no key_error.
REQ-032 SHALL verify that start pulsed during RUN with a different plaintext -> ignored; first result unchanged; key_advance pulsed exactly once.
REQ-033 SHALL verify that stalling the key source after key 5 for 8 cycles -> key_error pulse, no ct_valid, busy=0 next cycle; ciphertext keeps its prior value.
REQ-034 SHALL verify that rst_n=0 for one cycle after key 7 -> all outputs 0 next cycle; a following start on the FIPS vector completes correctly.
REQ-035 SHALL verify that round_key_valid pulsed while IDLE -> no state change; busy stays 0.

Source files
------------

// File: rtl/aes_round_engine.sv
// AES encryption datapath: one full round per accepted round key, fed by an external
// AES-256 key generator. Aborts with key_error if the generator stalls too long.
module aes_round_engine #(
  parameter int unsigned KEY_TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         key_advance,
  input  logic [127:0] round_key,
  input  logic         round_key_valid,
  output logic         busy,
  output logic [127:0] ciphertext,
  output logic         ct_valid,
  output logic         key_error
);

  localparam int unsigned TmoW = $clog2(KEY_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(KEY_TIMEOUT - 1);

  // Byte 0x00 sits in the top 8 bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {StIdle, StKick, StRun, StDone} state_e;

  state_e          st_q, st_d;
  logic [127:0]    data_q;
  logic [3:0]      key_idx_q;
  logic [TmoW-1:0] tmo_q;
  logic [127:0]    sr_vec, mc_vec, round_out;
  logic [31:0]     col;
  logic [7:0]      a0, a1, a2, a3;
  logic            key_fire, timeout;

  // SubBytes + ShiftRows fused: output (r,c) takes input (r,(c+r)%4).
  always_comb begin
    sr_vec = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_vec[127 - 8*(4*c + r) -: 8] = sub_byte(data_q[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
  end

  always_comb begin
    mc_vec = '0;
    col    = '0;
    a0     = '0;
    a1     = '0;
    a2     = '0;
    a3     = '0;
    for (int c = 0; c < 4; c++) begin
      col = sr_vec[127 - 32*c -: 32];
      a0  = col[31:24];
      a1  = col[23:16];
      a2  = col[15:8];
      a3  = col[7:0];
      mc_vec[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
  end

  always_comb begin
    if (key_idx_q == 4'd0) begin
      round_out = data_q ^ round_key;
    end else if (key_idx_q == 4'd14) begin
      round_out = sr_vec ^ round_key;
    end else begin
      round_out = mc_vec ^ round_key;
    end
  end

  assign key_fire = (st_q == StRun) && round_key_valid;
  // A key arriving on the last allowed cycle wins over the timeout.
  assign timeout  = (st_q == StRun) && !round_key_valid && (tmo_q == TmoLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      StIdle: if (start) st_d = StKick;
      StKick: st_d = StRun;
      StRun: begin
        if (key_fire && key_idx_q == 4'd14) begin
          st_d = StDone;
        end else if (timeout) begin
          st_d = StIdle;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    key_advance = (st_q == StKick);
    busy        = (st_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      ciphertext <= '0;
      key_idx_q  <= '0;
      tmo_q      <= '0;
      ct_valid   <= 1'b0;
      key_error  <= 1'b0;
    end else begin
      ct_valid  <= (st_q == StDone);
      key_error <= timeout;
      case (st_q)
        StIdle: begin
          if (start) begin
            data_q    <= plaintext;
            key_idx_q <= '0;
          end
        end
        StKick: tmo_q <= '0;
        StRun: begin
          if (key_fire) begin
            data_q    <= round_out;
            key_idx_q <= key_idx_q + 4'd1;
            tmo_q     <= '0;
          end else if (!timeout) begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDone: ciphertext <= data_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine: FIPS-197 C.3 vector with generated AES-256
// round keys, random key gaps, ignored start, key timeout, mid-block reset, stray keys.
module tb_aes_round_engine;

  localparam int unsigned KT = 8;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ALT_PT  = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [255:0] KEY     =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic         key_advance;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic         busy;
  logic [127:0] ciphertext;
  logic         ct_valid;
  logic         key_error;

  aes_round_engine #(.KEY_TIMEOUT(KT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .plaintext       (plaintext),
    .key_advance     (key_advance),
    .round_key       (round_key),
    .round_key_valid (round_key_valid),
    .busy            (busy),
    .ciphertext      (ciphertext),
    .ct_valid        (ct_valid),
    .key_error       (key_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_ct = 0;
  int n_kerr = 0;
  int n_kadv = 0;
  logic [127:0] sb_q[$];
  logic [127:0] sb_exp;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk [15];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // S-box from the GF(2^8) inverse and affine map; AES-256 schedule from it.
  task automatic build_keys();
    logic [7:0]  inv, b, rc;
    logic [31:0] w [60];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 8; i++) w[i] = KEY[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(negedge clk) begin
    if (key_advance) n_kadv++;
    if (key_error) n_kerr++;
    if (ct_valid) begin
      n_ct++;
      if (sb_q.size() == 0) begin
        check("ct_spurious", 128'(ct_valid), 128'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("ciphertext", ciphertext, sb_exp);
      end
    end
  end

  task automatic do_start(input logic [127:0] pt, input bit expect_ct);
    if (expect_ct) sb_q.push_back(FIPS_CT);
    start     = 1'b1;
    plaintext = pt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap < 0 means random 0..5 idle cycles before each key.
  task automatic feed(input int n, input int gap, input int poke);
    int w = 0;
    int g;
    while (!key_advance && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("kick", 128'(key_advance), 128'd1);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 5)) : gap;
      repeat (g) @(negedge clk);
      round_key       = rk[k];
      round_key_valid = 1'b1;
      @(negedge clk);
      round_key_valid = 1'b0;
      if (k == poke) begin
        start     = 1'b1;
        plaintext = ALT_PT;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_ct(input int target);
    int w = 0;
    while (n_ct < target && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ct_count", 128'(n_ct), 128'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ct0, ke0, ka0, stall;
    rst_n           = 1'b0;
    start           = 1'b0;
    plaintext       = '0;
    round_key       = '0;
    round_key_valid = 1'b0;
    build_keys();
    repeat (2) @(negedge clk);
    check("rst_key_advance", 128'(key_advance), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ct_valid", 128'(ct_valid), 128'd0);
    check("rst_key_error", 128'(key_error), 128'd0);
    check("rst_ciphertext", ciphertext, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Generator cadence: one key every 4 cycles.
    do_start(FIPS_PT, 1'b1);
    feed(15, 3, -1);
    wait_ct(1);

    // Random gaps.
    do_start(FIPS_PT, 1'b1);
    feed(15, -1, -1);
    wait_ct(2);

    // Start during RUN with other plaintext is ignored.
    ka0 = n_kadv;
    do_start(FIPS_PT, 1'b1);
    feed(15, -1, 3);
    wait_ct(3);
    check("kadv_once", 128'(n_kadv - ka0), 128'd1);
    check("no_kerr", 128'(n_kerr), 128'd0);

    // Stray key pulses while idle.
    round_key       = rk[4];
    round_key_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 128'(busy), 128'd0);
    end
    round_key_valid = 1'b0;
    check("idle_ct_hold", ciphertext, FIPS_CT);
    do_start(FIPS_PT, 1'b1);
    feed(15, -1, -1);
    wait_ct(4);

    // Generator stalls after key 5.
    ct0 = n_ct;
    ke0 = n_kerr;
    do_start(FIPS_PT, 1'b0);
    feed(6, -1, -1);
    stall = 0;
    while (!key_error && stall < 3 * KT) begin
      @(posedge clk);
      stall++;
      @(negedge clk);
    end
    check("stall_cycles", 128'(stall), 128'(KT));
    check("err_busy", 128'(busy), 128'd0);
    @(negedge clk);
    check("err_pulse_width", 128'(key_error), 128'd0);
    check("err_busy_next", 128'(busy), 128'd0);
    check("err_ct_hold", ciphertext, FIPS_CT);
    check("err_no_ct", 128'(n_ct - ct0), 128'd0);
    check("err_count", 128'(n_kerr - ke0), 128'd1);

    // Reset after key 7.
    ct0 = n_ct;
    ke0 = n_kerr;
    do_start(FIPS_PT, 1'b0);
    feed(8, -1, -1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_key_advance", 128'(key_advance), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_ct_valid", 128'(ct_valid), 128'd0);
    check("mid_rst_key_error", 128'(key_error), 128'd0);
    check("mid_rst_ciphertext", ciphertext, 128'd0);
    repeat (KT + 4) @(negedge clk);
    check("mid_rst_no_ct", 128'(n_ct - ct0), 128'd0);
    check("mid_rst_no_kerr", 128'(n_kerr - ke0), 128'd0);
    do_start(FIPS_PT, 1'b1);
    feed(15, -1, -1);
    wait_ct(ct0 + 1);

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
